default_slave: RTL and testbench



---
 rtl/default_slave_pkg.sv | 37 +++
 rtl/default_slave_if.sv | 95 +++++++++
 rtl/default_slave.sv | 238 +++++++++++++++++++++++
 tb/tb_default_slave.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/default_slave_pkg.sv
// -----------------------------------------------------------------------------
// default_slave_pkg
// Shared AXI definitions for the default (unmapped-address) slave:
//   - response codes RESP_OKAY / RESP_DECERR
//   - read FSM states  rd_state_t {R_IDLE, R_DATA}
//   - write FSM states wr_state_t {W_ADDR, W_DATA, W_RESP}
// The AXI width macros normally come from AXI_define.svh. When that header has
// not been pulled in, the fallback values below keep standalone builds working.
// Optional feature macro used by this slice: DEFAULT_SLAVE_ERRLOG_EN.
// -----------------------------------------------------------------------------
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif

package default_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        W_ADDR,
        W_DATA,
        W_RESP
    } wr_state_t;

endpackage

// File: rtl/default_slave_if.sv
// -----------------------------------------------------------------------------
// default_slave_if
// AXI channel bundle between the address decoder / response mux and the
// default slave. Only the fields the default slave needs are carried.
//   AR : ARID, ARLEN, ARVALID -> ARREADY
//   R  : RID, RDATA, RRESP, RLAST, RVALID <- RREADY
//   AW : AWID, AWLEN, AWVALID -> AWREADY
//   W  : WDATA, WSTRB, WLAST, WVALID -> WREADY
//   B  : BID, BRESP, BVALID <- BREADY
// With DEFAULT_SLAVE_ERRLOG_EN defined, ARADDR/AWADDR (32 bits) are added so
// the slave can log the offending address.
// Modports: master (decoder side), slave (default slave side).
// -----------------------------------------------------------------------------
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif

interface default_slave_if #(
    parameter int ID_W   = `AXI_IDS_BITS,
    parameter int DATA_W = `AXI_DATA_BITS,
    parameter int LEN_W  = `AXI_LEN_BITS
) ();

    logic [ID_W-1:0]     ARID;
    logic [LEN_W-1:0]    ARLEN;
    logic                ARVALID;
    logic                ARREADY;

    logic [ID_W-1:0]     RID;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
    logic                RREADY;

    logic [ID_W-1:0]     AWID;
    logic [LEN_W-1:0]    AWLEN;
    logic                AWVALID;
    logic                AWREADY;

    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;

    logic [ID_W-1:0]     BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

`ifdef DEFAULT_SLAVE_ERRLOG_EN
    logic [31:0]         ARADDR;
    logic [31:0]         AWADDR;
`endif

    modport master (
        output ARID, ARLEN, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        output AWID, AWLEN, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
`ifdef DEFAULT_SLAVE_ERRLOG_EN
        , output ARADDR, AWADDR
`endif
    );

    modport slave (
        input  ARID, ARLEN, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        input  AWID, AWLEN, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
`ifdef DEFAULT_SLAVE_ERRLOG_EN
        , input ARADDR, AWADDR
`endif
    );

endinterface

// File: rtl/default_slave.sv
// -----------------------------------------------------------------------------
// default_slave
// Terminates every AXI read or write that decodes to no mapped slave. Reads
// return ARLEN+1 beats of zero data with DECERR; writes swallow all W beats up
// to WLAST and answer with a single DECERR on B. Read and write paths are
// independent FSMs so neither can stall the other.
//
// Ports:
//   ACLK      clock
//   ARESET    asynchronous active-high reset
//   bus       default_slave_if.slave (AR/R/AW/W/B channels)
//   err_cnt   [15:0] saturating count of accepted AR+AW   (ERRLOG only)
//   err_addr  [31:0] most recent offending address        (ERRLOG only)
//
// Build option: define DEFAULT_SLAVE_ERRLOG_EN to add err_cnt/err_addr and
// the ARADDR/AWADDR interface fields.
//
// Every output is decoded from registered state only, so there is no
// combinational input-to-output path.
// -----------------------------------------------------------------------------
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif

module default_slave
    import default_slave_pkg::*;
#(
    parameter int ID_W   = `AXI_IDS_BITS,
    parameter int DATA_W = `AXI_DATA_BITS,
    parameter int LEN_W  = `AXI_LEN_BITS
) (
    input  logic               ACLK,
    input  logic               ARESET,
    default_slave_if.slave     bus
`ifdef DEFAULT_SLAVE_ERRLOG_EN
    ,
    output logic [15:0]        err_cnt,
    output logic [31:0]        err_addr
`endif
);

    // Low during reset, high from the first clock after release. Gating the
    // address READYs with it keeps them at 0 while ARESET is asserted.
    logic ready_en_reg;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
        end
    end

    // ------------------------------------------------------------------ read
    rd_state_t        rd_state_reg, rd_state_next;
    logic [ID_W-1:0]  rid_reg;
    logic [LEN_W-1:0] rlen_reg;
    logic [LEN_W-1:0] rbeat_reg;
    logic             arready;
    logic             rvalid;
    logic             rlast;
    logic [1:0]       rresp;
    logic             ar_hs;
    logic             r_hs;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_state_reg <= R_IDLE;
        end else begin
            rd_state_reg <= rd_state_next;
        end
    end

    always_comb begin
        rd_state_next = rd_state_reg;
        arready       = 1'b0;
        rvalid        = 1'b0;
        rlast         = 1'b0;
        rresp         = RESP_OKAY;
        unique case (rd_state_reg)
            R_IDLE: begin
                arready = ready_en_reg;
                if (bus.ARVALID && ready_en_reg) begin
                    rd_state_next = R_DATA;
                end
            end
            R_DATA: begin
                rvalid = 1'b1;
                rresp  = RESP_DECERR;
                rlast  = (rbeat_reg == rlen_reg);
                if (bus.RREADY && rlast) begin
                    rd_state_next = R_IDLE;
                end
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    assign ar_hs = arready && bus.ARVALID;
    assign r_hs  = rvalid && bus.RREADY;

    // The beat counter stops at the captured length, so it never wraps.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rid_reg   <= '0;
            rlen_reg  <= '0;
            rbeat_reg <= '0;
        end else if (ar_hs) begin
            rid_reg   <= bus.ARID;
            rlen_reg  <= bus.ARLEN;
            rbeat_reg <= '0;
        end else if (r_hs && !rlast) begin
            rbeat_reg <= rbeat_reg + LEN_W'(1);
        end
    end

    assign bus.ARREADY = arready;
    assign bus.RVALID  = rvalid;
    assign bus.RLAST   = rlast;
    assign bus.RRESP   = rresp;
    assign bus.RID     = rid_reg;
    assign bus.RDATA   = '0;

    // ----------------------------------------------------------------- write
    wr_state_t        wr_state_reg, wr_state_next;
    logic [ID_W-1:0]  bid_reg;
    logic             awready;
    logic             wready;
    logic             bvalid;
    logic [1:0]       bresp;
    logic             aw_hs;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state_reg <= W_ADDR;
        end else begin
            wr_state_reg <= wr_state_next;
        end
    end

    // WLAST alone ends the burst; AWLEN is not used to count beats.
    always_comb begin
        wr_state_next = wr_state_reg;
        awready       = 1'b0;
        wready        = 1'b0;
        bvalid        = 1'b0;
        bresp         = RESP_OKAY;
        unique case (wr_state_reg)
            W_ADDR: begin
                awready = ready_en_reg;
                if (bus.AWVALID && ready_en_reg) begin
                    wr_state_next = W_DATA;
                end
            end
            W_DATA: begin
                wready = 1'b1;
                if (bus.WVALID && bus.WLAST) begin
                    wr_state_next = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                bresp  = RESP_DECERR;
                if (bus.BREADY) begin
                    wr_state_next = W_ADDR;
                end
            end
            default: wr_state_next = W_ADDR;
        endcase
    end

    assign aw_hs = awready && bus.AWVALID;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            bid_reg <= '0;
        end else if (aw_hs) begin
            bid_reg <= bus.AWID;
        end
    end

    assign bus.AWREADY = awready;
    assign bus.WREADY  = wready;
    assign bus.BVALID  = bvalid;
    assign bus.BRESP   = bresp;
    assign bus.BID     = bid_reg;

    // Write payload and burst length are deliberately discarded.
    logic unused_inputs;
    assign unused_inputs = ^{bus.AWLEN, bus.WDATA, bus.WSTRB};

    // ------------------------------------------------------------- error log
`ifdef DEFAULT_SLAVE_ERRLOG_EN
    logic [15:0] err_cnt_reg, err_cnt_next;
    logic [31:0] err_addr_reg;

    // Saturating add of 0, 1 or 2 accepted address phases this cycle.
    always_comb begin
        err_cnt_next = err_cnt_reg;
        unique case ({ar_hs, aw_hs})
            2'b11: begin
                err_cnt_next = (err_cnt_reg >= 16'hFFFE) ? 16'hFFFF
                                                         : err_cnt_reg + 16'd2;
            end
            2'b10, 2'b01: begin
                err_cnt_next = (err_cnt_reg == 16'hFFFF) ? 16'hFFFF
                                                         : err_cnt_reg + 16'd1;
            end
            default: err_cnt_next = err_cnt_reg;
        endcase
    end

    // On a simultaneous AR/AW handshake the write address wins.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            err_cnt_reg  <= '0;
            err_addr_reg <= '0;
        end else begin
            err_cnt_reg <= err_cnt_next;
            if (aw_hs) begin
                err_addr_reg <= bus.AWADDR;
            end else if (ar_hs) begin
                err_addr_reg <= bus.ARADDR;
            end
        end
    end

    assign err_cnt  = err_cnt_reg;
    assign err_addr = err_addr_reg;
`endif

endmodule

// File: tb/tb_default_slave.sv
// -----------------------------------------------------------------------------
// tb_default_slave
// Self-checking bench for default_slave. A transaction-level reference model
// (outstanding read burst with beat index, and counters of accepted AW, WLAST
// and B handshakes) predicts every handshake signal and response field each
// cycle. Directed scenarios come first, followed by randomized traffic.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_default_slave;

    localparam int ID_W   = 8;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    default_slave_if #(.ID_W(ID_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

`ifdef DEFAULT_SLAVE_ERRLOG_EN
    logic [15:0] err_cnt;
    logic [31:0] err_addr;
`endif

    default_slave #(.ID_W(ID_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .bus    (bus)
`ifdef DEFAULT_SLAVE_ERRLOG_EN
        ,
        .err_cnt  (err_cnt),
        .err_addr (err_addr)
`endif
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    bit m_started;
    bit m_rd_busy;
    int m_rd_id, m_rd_len, m_rd_beat;
    int m_aw_n, m_wl_n, m_b_n;
    int m_wr_id;
    int m_err_cnt;
    longint m_err_addr;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_rd_busy = 0;
        m_rd_id = 0; m_rd_len = 0; m_rd_beat = 0;
        m_aw_n = 0; m_wl_n = 0; m_b_n = 0; m_wr_id = 0;
        m_err_cnt = 0; m_err_addr = 0;
    endtask

    task automatic idle_inputs();
        bus.ARID = '0; bus.ARLEN = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
        bus.AWID = '0; bus.AWLEN = '0; bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
        bus.BREADY = 1'b0;
`ifdef DEFAULT_SLAVE_ERRLOG_EN
        bus.ARADDR = '0; bus.AWADDR = '0;
`endif
    endtask

    // Compare all DUT outputs with the model's prediction for this cycle.
    task automatic check_outputs();
        check_eq("arready", bus.ARREADY, m_started && !m_rd_busy);
        check_eq("rvalid",  bus.RVALID,  m_rd_busy);
        check_eq("rlast",   bus.RLAST,   m_rd_busy && (m_rd_beat == m_rd_len));
        if (m_rd_busy) begin
            check_eq("rid",   bus.RID,   m_rd_id);
            check_eq("rresp", bus.RRESP, 2'b11);
            check_eq("rdata", bus.RDATA, 0);
        end else begin
            check_eq("rresp_idle", bus.RRESP, 2'b00);
        end
        check_eq("awready", bus.AWREADY, m_started && (m_aw_n == m_b_n));
        check_eq("wready",  bus.WREADY,  m_aw_n > m_wl_n);
        check_eq("bvalid",  bus.BVALID,  m_wl_n > m_b_n);
        if (m_wl_n > m_b_n) begin
            check_eq("bid",   bus.BID,   m_wr_id);
            check_eq("bresp", bus.BRESP, 2'b11);
        end else begin
            check_eq("bresp_idle", bus.BRESP, 2'b00);
        end
`ifdef DEFAULT_SLAVE_ERRLOG_EN
        check_eq("err_cnt",  err_cnt,  m_err_cnt);
        check_eq("err_addr", err_addr, m_err_addr);
`endif
    endtask

    task automatic check_reset_values();
        check_eq("rst_arready", bus.ARREADY, 0);
        check_eq("rst_awready", bus.AWREADY, 0);
        check_eq("rst_rvalid",  bus.RVALID,  0);
        check_eq("rst_wready",  bus.WREADY,  0);
        check_eq("rst_bvalid",  bus.BVALID,  0);
        check_eq("rst_rlast",   bus.RLAST,   0);
        check_eq("rst_rid",     bus.RID,     0);
        check_eq("rst_bid",     bus.BID,     0);
        check_eq("rst_rresp",   bus.RRESP,   0);
        check_eq("rst_bresp",   bus.BRESP,   0);
`ifdef DEFAULT_SLAVE_ERRLOG_EN
        check_eq("rst_err_cnt",  err_cnt,  0);
        check_eq("rst_err_addr", err_addr, 0);
`endif
    endtask

    // Called at a falling edge with inputs already set: predicts the
    // handshakes of the coming rising edge, advances the model, then checks.
    task automatic cycle();
        bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
        ar_hs = m_started && !m_rd_busy && bus.ARVALID;
        r_hs  = m_rd_busy && bus.RREADY;
        aw_hs = m_started && (m_aw_n == m_b_n) && bus.AWVALID;
        w_hs  = (m_aw_n > m_wl_n) && bus.WVALID;
        b_hs  = (m_wl_n > m_b_n) && bus.BREADY;
        if (r_hs) begin
            if (m_rd_beat == m_rd_len) begin
                m_rd_busy = 0;
                $display("RD  id=0x%02h beats=%0d DECERR", m_rd_id[7:0], m_rd_len + 1);
            end else begin
                m_rd_beat++;
            end
        end
        if (ar_hs) begin
            m_rd_busy = 1; m_rd_id = int'(bus.ARID); m_rd_len = int'(bus.ARLEN); m_rd_beat = 0;
        end
        if (aw_hs) begin
            m_aw_n++; m_wr_id = int'(bus.AWID);
        end
        if (w_hs && bus.WLAST) m_wl_n++;
        if (b_hs) begin
            m_b_n++;
            $display("WR  id=0x%02h DECERR", m_wr_id[7:0]);
        end
`ifdef DEFAULT_SLAVE_ERRLOG_EN
        m_err_cnt = m_err_cnt + int'(ar_hs) + int'(aw_hs);
        if (m_err_cnt > 65535) m_err_cnt = 65535;
        if (aw_hs) m_err_addr = longint'(bus.AWADDR);
        else if (ar_hs) m_err_addr = longint'(bus.ARADDR);
`endif
        m_started = 1;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    int beats_seen;

    initial begin
        idle_inputs();
        model_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values();
        check_outputs();
        rst = 1'b0;
        cycle();                       // ready_en comes up on this edge

        // Read burst: ID 0x12, LEN 3, RREADY held high
        bus.ARVALID = 1'b1; bus.ARID = 8'h12; bus.ARLEN = 4'd3; bus.RREADY = 1'b1;
        cycle();
        bus.ARVALID = 1'b0;
        beats_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.RVALID === 1'b1) beats_seen++;
            cycle();
        end
        check_eq("burst_beats", beats_seen, 4);

        // Read backpressure: LEN 1, RREADY low for 3 cycles on beat 1
        bus.ARVALID = 1'b1; bus.ARID = 8'h44; bus.ARLEN = 4'd1; bus.RREADY = 1'b0;
        cycle();
        bus.ARVALID = 1'b0;
        run_cycles(3);
        bus.RREADY = 1'b1;
        run_cycles(3);

        // Early W beat before any AW must not be accepted
        bus.WVALID = 1'b1; bus.WLAST = 1'b1;
        run_cycles(2);
        bus.WVALID = 1'b0; bus.WLAST = 1'b0;

        // Write burst: ID 0x05, 4 beats, BREADY low for 2 cycles
        bus.AWVALID = 1'b1; bus.AWID = 8'h05; bus.AWLEN = 4'd3;
        cycle();
        bus.AWVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.WVALID = 1'b1; bus.WDATA = $urandom; bus.WSTRB = 4'hF;
            bus.WLAST  = (i == 3);
            cycle();
        end
        bus.WVALID = 1'b0; bus.WLAST = 1'b0;
        run_cycles(2);
        bus.BREADY = 1'b1;
        run_cycles(2);
        bus.BREADY = 1'b0;

        // Concurrent AR (ID 1, LEN 0) and AW (ID 2)
        bus.ARVALID = 1'b1; bus.ARID = 8'h01; bus.ARLEN = 4'd0;
        bus.AWVALID = 1'b1; bus.AWID = 8'h02; bus.AWLEN = 4'd0;
        bus.RREADY = 1'b0;
        cycle();
        bus.ARVALID = 1'b0; bus.AWVALID = 1'b0;
        bus.WVALID = 1'b1; bus.WLAST = 1'b1;
        cycle();
        bus.WVALID = 1'b0; bus.WLAST = 1'b0;
        bus.RREADY = 1'b1; bus.BREADY = 1'b1;
        run_cycles(3);
        bus.BREADY = 1'b0;

        // Reset in the middle of a LEN 7 read burst
        bus.ARVALID = 1'b1; bus.ARID = 8'h77; bus.ARLEN = 4'd7; bus.RREADY = 1'b1;
        cycle();
        bus.ARVALID = 1'b0;
        run_cycles(2);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rvalid",  bus.RVALID,  0);
        check_eq("async_arready", bus.ARREADY, 0);
        model_reset();
        @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        check_outputs();
        cycle();
        bus.ARVALID = 1'b1; bus.ARID = 8'h33; bus.ARLEN = 4'd2; bus.RREADY = 1'b1;
        cycle();
        bus.ARVALID = 1'b0;
        run_cycles(4);

`ifdef DEFAULT_SLAVE_ERRLOG_EN
        // Error log: 3 reads then 1 write, counter starts from reset
        idle_inputs();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle();
        bus.RREADY = 1'b1; bus.BREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.ARVALID = 1'b1; bus.ARID = 8'(i); bus.ARLEN = '0; bus.ARADDR = 32'h0002_0000;
            cycle();
            bus.ARVALID = 1'b0;
            cycle();
        end
        bus.AWVALID = 1'b1; bus.AWID = 8'h09; bus.AWADDR = 32'h0003_0010;
        cycle();
        bus.AWVALID = 1'b0;
        bus.WVALID = 1'b1; bus.WLAST = 1'b1;
        cycle();
        bus.WVALID = 1'b0; bus.WLAST = 1'b0;
        run_cycles(2);
        check_eq("errlog_cnt",  err_cnt,  16'd4);
        check_eq("errlog_addr", err_addr, 32'h0003_0010);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.ARVALID = ($urandom_range(0, 99) < 40);
            bus.ARID    = 8'($urandom);
            bus.ARLEN   = 4'($urandom);
            bus.RREADY  = ($urandom_range(0, 99) < 70);
            bus.AWVALID = ($urandom_range(0, 99) < 40);
            bus.AWID    = 8'($urandom);
            bus.AWLEN   = 4'($urandom);
            bus.WVALID  = ($urandom_range(0, 99) < 60);
            bus.WDATA   = $urandom;
            bus.WSTRB   = 4'($urandom);
            bus.WLAST   = ($urandom_range(0, 99) < 30);
            bus.BREADY  = ($urandom_range(0, 99) < 60);
`ifdef DEFAULT_SLAVE_ERRLOG_EN
            bus.ARADDR  = $urandom;
            bus.AWADDR  = $urandom;
`endif
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
